wb_stage: RTL and testbench

//  Writeback stage of the MyProc2 5-stage pipeline; sits directly downstream of MEM.

---
 rtl/wb_stage_pkg.sv | 29 ++
 rtl/wb_dest_decode.sv | 31 +++
 rtl/wb_stage.sv | 123 ++++++++++++
 tb/tb_wb_stage.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// Shared constants for the MyProc2 writeback stage: datapath sizes, WB state
// encodings, opcode values and small decode helpers.
package wb_stage_pkg;

    localparam int WB_WIDTH  = 32;
    localparam int WB_REG_AW = 5;

    localparam logic WB_RUN    = 1'b0;
    localparam logic WB_HALTED = 1'b1;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LD    = 6'h37;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_SD    = 6'h3F;
    localparam logic [5:0] OP_HALT  = 6'h3E;

    // Immediate ALU group occupies opcodes 0x08..0x0F.
    function automatic logic is_imm_alu(input logic [5:0] op);
        return op[5:3] == 3'b001;
    endfunction

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LD);
    endfunction

endpackage

// File: rtl/wb_dest_decode.sv
// Combinational destination-register decode (IR -> {writes, dest}).
// Shared with the hazard unit; dest reads 0 whenever the instruction does not write.
module wb_dest_decode
    import wb_stage_pkg::*;
#(
    parameter int WIDTH  = WB_WIDTH,
    parameter int REG_AW = WB_REG_AW
) (
    input  logic [WIDTH-1:0]  ir,
    output logic              writes,
    output logic [REG_AW-1:0] dest
);

    logic [5:0] op;

    assign op = ir[WIDTH-1 -: 6];

    always_comb begin
        writes = 1'b0;
        dest   = '0;
        // An all-zero IR is a NOP even though its opcode field is R-type.
        if (op == OP_RTYPE && ir != '0) begin
            writes = 1'b1;
            dest   = ir[11 +: REG_AW];
        end else if (is_load(op) || is_imm_alu(op)) begin
            writes = 1'b1;
            dest   = ir[16 +: REG_AW];
        end
    end

endmodule

// File: rtl/wb_stage.sv
// MyProc2 writeback stage: MEM/WB register, destination decode, load alignment,
// forwarding bypass and HALT handling. Optional retire counter via WB_RETIRE_CNT_EN.
//
// state      | meaning
// WB_RUN     | normal operation, register loads and writes retire
// WB_HALTED  | HALT retired; register frozen, no writes until rst
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int WIDTH  = WB_WIDTH,
    parameter int REG_AW = WB_REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  IR_in,
    input  logic [WIDTH-3:0]  PC_in,
    input  logic [WIDTH-1:0]  Z_in,
    input  logic              valid_in,
    input  logic              stall,
    input  logic              flush,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [WIDTH-1:0]  rf_wdata,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_addr,
    output logic [WIDTH-1:0]  fwd_data,
    output logic [WIDTH-3:0]  PC_out,
    output logic              halted
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [WIDTH-1:0]  retire_cnt
`endif
);

    logic [WIDTH-1:0]  ir_q;
    logic [WIDTH-3:0]  pc_q;
    logic [WIDTH-1:0]  z_q;
    logic              valid_q;
    logic              state_q;

    logic [5:0]        op_q;
    logic              running;
    logic              halt_q;
    logic              load_en;
    logic              retire;
    logic              dest_writes;
    logic [REG_AW-1:0] dest;
    logic              we;
    logic [WIDTH-1:0]  wdata;

    assign op_q    = ir_q[WIDTH-1 -: 6];
    assign running = (state_q == WB_RUN);
    assign halt_q  = valid_q && (op_q == OP_HALT);

    // A HALT sitting in the register blocks the next load, so a trailing instruction is dropped.
    assign load_en = running && !halt_q && (flush || !stall);
    assign retire  = running && valid_q && (flush || !stall || halt_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q    <= '0;
            pc_q    <= '0;
            z_q     <= '0;
            valid_q <= 1'b0;
            state_q <= WB_RUN;
        end else begin
            if (load_en) begin
                ir_q    <= flush ? '0 : IR_in;
                valid_q <= flush ? 1'b0 : valid_in;
                pc_q    <= PC_in;
                z_q     <= Z_in;
            end
            if (running && halt_q) begin
                state_q <= WB_HALTED;
            end
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [WIDTH-1:0] retire_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt_q <= '0;
        end else if (retire) begin
            retire_cnt_q <= retire_cnt_q + 1'b1;
        end
    end

    assign retire_cnt = retire_cnt_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

    wb_dest_decode #(
        .WIDTH  (WIDTH),
        .REG_AW (REG_AW)
    ) u_dest_decode (
        .ir     (ir_q),
        .writes (dest_writes),
        .dest   (dest)
    );

    always_comb begin
        we = valid_q && dest_writes && (dest != '0) && running;
        if (op_q == OP_LH) begin
            wdata = {{(WIDTH-16){z_q[15]}}, z_q[15:0]};
        end else begin
            wdata = z_q;
        end
    end

    assign rf_we     = we;
    assign rf_waddr  = we ? dest : '0;
    assign rf_wdata  = wdata;
    assign fwd_valid = we;
    assign fwd_addr  = we ? dest : '0;
    assign fwd_data  = wdata;
    assign PC_out    = pc_q;
    assign halted    = (state_q == WB_HALTED);

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed steps push expected post-edge outputs,
// a negedge monitor pops and compares them. Checks retire_cnt when WB_RETIRE_CNT_EN is set.
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic [31:0] IR_in;
    logic [29:0] PC_in;
    logic [31:0] Z_in;
    logic        valid_in;
    logic        stall;
    logic        flush;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
    logic [29:0] PC_out;
    logic        halted;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    wb_stage dut (
        .clk       (clk),
        .rst       (rst),
        .IR_in     (IR_in),
        .PC_in     (PC_in),
        .Z_in      (Z_in),
        .valid_in  (valid_in),
        .stall     (stall),
        .flush     (flush),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .fwd_valid (fwd_valid),
        .fwd_addr  (fwd_addr),
        .fwd_data  (fwd_data),
        .PC_out    (PC_out),
        .halted    (halted)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_cnt(retire_cnt)
`endif
    );

    typedef struct {
        int          cyc;
        int          tag;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        cd;
        logic [29:0] pc;
        logic        hlt;
        logic [31:0] rc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    // Instruction encodings used by the vectors.
    localparam logic [31:0] I_ADD_R5   = {6'h00, 5'd1, 5'd2, 5'd5, 5'd0, 6'h20};
    localparam logic [31:0] I_LH_R7    = {6'h21, 5'd1, 5'd7, 16'h0000};
    localparam logic [31:0] I_LW_R7    = {6'h23, 5'd1, 5'd7, 16'h0000};
    localparam logic [31:0] I_SW_R7    = {6'h2B, 5'd1, 5'd7, 16'h0000};
    localparam logic [31:0] I_ADDI_R0  = {6'h08, 5'd1, 5'd0, 16'h0005};
    localparam logic [31:0] I_ADDI_R9  = {6'h08, 5'd1, 5'd9, 16'h0004};
    localparam logic [31:0] I_HALT     = {6'h3E, 26'h0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input int tag, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL step %0d %s: got 0x%08h expected 0x%08h", tag, nm, act, exp);
        end
    endtask

    task automatic step(input int tag, input logic r, input logic [31:0] ir, input logic [29:0] pc,
                        input logic [31:0] z, input logic v, input logic st, input logic fl,
                        input logic e_we, input logic [4:0] e_addr, input logic [31:0] e_data,
                        input logic e_cd, input logic [29:0] e_pc, input logic e_h,
                        input logic [31:0] e_rc);
        exp_t e;
        @(posedge clk);
        #2;
        rst      = r;
        IR_in    = ir;
        PC_in    = pc;
        Z_in     = z;
        valid_in = v;
        stall    = st;
        flush    = fl;
        e.cyc  = cyc + 1;
        e.tag  = tag;
        e.we   = e_we;
        e.addr = e_addr;
        e.data = e_data;
        e.cd   = e_cd;
        e.pc   = e_pc;
        e.hlt  = e_h;
        e.rc   = e_rc;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                if (e.cyc != cyc) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL step %0d sample: got cycle %0d expected cycle %0d", e.tag, cyc, e.cyc);
                end else begin
                    chk(e.tag, "rf_we", {31'b0, rf_we}, {31'b0, e.we});
                    chk(e.tag, "rf_waddr", {27'b0, rf_waddr}, {27'b0, e.addr});
                    chk(e.tag, "fwd_valid", {31'b0, fwd_valid}, {31'b0, e.we});
                    chk(e.tag, "fwd_addr", {27'b0, fwd_addr}, {27'b0, e.addr});
                    if (e.cd) begin
                        chk(e.tag, "rf_wdata", rf_wdata, e.data);
                        chk(e.tag, "fwd_data", fwd_data, e.data);
                    end
                    chk(e.tag, "PC_out", {2'b0, PC_out}, {2'b0, e.pc});
                    chk(e.tag, "halted", {31'b0, halted}, {31'b0, e.hlt});
`ifdef WB_RETIRE_CNT_EN
                    chk(e.tag, "retire_cnt", retire_cnt, e.rc);
`endif
                end
            end
        end
    end

    initial begin : stimulus
        rst      = 1'b1;
        IR_in    = '0;
        PC_in    = '0;
        Z_in     = '0;
        valid_in = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;

        //   tag rst IR          PC      Z             v  st fl | we addr data          cd pc      h  rc
        step( 1, 1, '0,         30'h00, 32'h0,        0, 0, 0,  0, 0, 32'h0,         1, 30'h00, 0, 0);
        step( 2, 1, '0,         30'h00, 32'h0,        0, 0, 0,  0, 0, 32'h0,         1, 30'h00, 0, 0);
        step( 3, 0, '0,         30'h00, 32'h0,        0, 0, 0,  0, 0, 32'h0,         1, 30'h00, 0, 0);
        step( 4, 0, I_ADD_R5,   30'h10, 32'h1234,     1, 0, 0,  1, 5, 32'h1234,      1, 30'h10, 0, 0);
        step( 5, 0, I_LH_R7,    30'h11, 32'h8001,     1, 0, 0,  1, 7, 32'hFFFF_8001, 1, 30'h11, 0, 1);
        step( 6, 0, I_LW_R7,    30'h12, 32'h8001,     1, 0, 0,  1, 7, 32'h0000_8001, 1, 30'h12, 0, 2);
        step( 7, 0, I_SW_R7,    30'h13, 32'hAAAA,     1, 0, 0,  0, 0, 32'h0,         0, 30'h13, 0, 3);
        step( 8, 0, I_ADDI_R0,  30'h14, 32'h55,       1, 0, 0,  0, 0, 32'h55,        1, 30'h14, 0, 4);
        step( 9, 0, I_ADDI_R9,  30'h15, 32'h77,       1, 0, 0,  1, 9, 32'h77,        1, 30'h15, 0, 5);
        for (int i = 0; i < 3; i++)
            step(10 + i, 0, I_ADD_R5, 30'h20, 32'hDEAD, 1, 1, 0, 1, 9, 32'h77,      1, 30'h15, 0, 5);
        step(13, 0, '0,         30'h16, 32'h0,        0, 0, 0,  0, 0, 32'h0,         1, 30'h16, 0, 6);
        step(14, 0, I_ADD_R5,   30'h17, 32'h1,        1, 0, 0,  1, 5, 32'h1,         1, 30'h17, 0, 6);
        step(15, 0, I_ADDI_R9,  30'h18, 32'h99,       1, 1, 1,  0, 0, 32'h0,         0, 30'h18, 0, 7);
        step(16, 0, I_HALT,     30'h19, 32'h0,        1, 0, 0,  0, 0, 32'h0,         0, 30'h19, 0, 7);
        step(17, 0, I_ADD_R5,   30'h1A, 32'h5,        1, 0, 0,  0, 0, 32'h0,         0, 30'h19, 1, 8);
        step(18, 0, I_ADD_R5,   30'h1B, 32'h6,        1, 0, 0,  0, 0, 32'h0,         0, 30'h19, 1, 8);
        step(19, 1, I_ADD_R5,   30'h1C, 32'h7,        1, 0, 0,  0, 0, 32'h0,         1, 30'h00, 0, 0);
        step(20, 0, I_ADD_R5,   30'h30, 32'h42,       1, 0, 0,  1, 5, 32'h42,        1, 30'h30, 0, 0);
        step(21, 0, I_ADD_R5,   30'h31, 32'h43,       0, 0, 0,  0, 0, 32'h0,         0, 30'h31, 0, 1);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (sb.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: got %0d pending entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
